// File: rtl/kan_grid_streamer.sv
// rtl/kan_grid_streamer.sv - grid RAM replayed as an AXI-Stream channel, one sweep per pass
module kan_grid_streamer #(
    parameter int DATA_WIDTH  = 16,
    parameter int GRID_DEPTH  = 64,
    parameter int ADDR_WIDTH  = $clog2(GRID_DEPTH),
    parameter int CNT_WIDTH   = 16,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 0,
    parameter int USER_WIDTH  = 8,
    parameter int OUTPUT_ID   = 1,
    parameter int OUTPUT_DEST = 0
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0]                         cfg_wr_addr,
    input  logic [DATA_WIDTH-1:0]                         cfg_wr_data,
    input  logic                                          start,
    input  logic [ADDR_WIDTH:0]                           grid_len,
    input  logic [CNT_WIDTH-1:0]                          pass_count,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err_cfg,
    output logic [DATA_WIDTH-1:0]                         m_axis_grid_tdata,
    output logic                                          m_axis_grid_tvalid,
    input  logic                                          m_axis_grid_tready,
    output logic                                          m_axis_grid_tlast,
    output logic [(ID_ENABLE != 0 ? ID_WIDTH : 1)-1:0]    m_axis_grid_tid,
    output logic [(DEST_ENABLE != 0 ? DEST_WIDTH : 1)-1:0] m_axis_grid_tdest,
    output logic [(USER_ENABLE != 0 ? USER_WIDTH : 1)-1:0] m_axis_grid_tuser
);

    localparam int IDW = (ID_ENABLE != 0) ? ID_WIDTH : 1;
    localparam int DSW = (DEST_ENABLE != 0) ? DEST_WIDTH : 1;
    localparam int LW  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START_CHK,
        S_STREAM,
        S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          len_q, len_d;
    logic [CNT_WIDTH-1:0]   pass_q, pass_d;
    logic [ADDR_WIDTH-1:0]  i_q, i_d;
    logic [CNT_WIDTH-1:0]   p_q, p_d;
    logic                   issued_all_q, issued_all_d;

    // Grid RAM and its read-data register (one cycle read latency).
    logic [DATA_WIDTH-1:0]  mem [GRID_DEPTH];
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   pend_q, pend_last_q, pend_fin_q;

    // Two-entry output FIFO; reads are only issued when a slot is guaranteed.
    logic [DATA_WIDTH-1:0]  fifo_data [2];
    logic                   fifo_last [2];
    logic                   fifo_fin  [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             count_q;

    logic                   cfg_ok, tvalid_int, pop, head_fin;
    logic                   can_issue, issue, issue_last, issue_fin, wr_ok;
    logic [2:0]             occ;

    // Datapath decode: legality, handshake, read-issue credit and write gating.
    always_comb begin
        cfg_ok     = (len_q != '0) && (len_q <= LW'(GRID_DEPTH)) && (pass_q != '0);
        tvalid_int = (count_q != 2'd0);
        pop        = tvalid_int && m_axis_grid_tready;
        head_fin   = fifo_fin[rd_ptr_q];
        occ        = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
        can_issue  = ((state_q == S_START_CHK) && cfg_ok) ||
                     ((state_q == S_STREAM) && !issued_all_q);
        issue      = can_issue && (occ < 3'd2);
        issue_last = ({1'b0, i_q} == (len_q - LW'(1)));
        issue_fin  = issue_last && (p_q == (pass_q - CNT_WIDTH'(1)));
        wr_ok      = cfg_wr_en && (state_q == S_IDLE) &&
                     ({1'b0, cfg_wr_addr} < LW'(GRID_DEPTH));
    end

    // Next-state logic for the run FSM and the read-side point/pass counters.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        pass_d       = pass_q;
        i_d          = i_q;
        p_d          = p_q;
        issued_all_d = issued_all_q;
        done         = 1'b0;
        err_cfg      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_START_CHK;
                    len_d        = grid_len;
                    pass_d       = pass_count;
                    i_d          = '0;
                    p_d          = '0;
                    issued_all_d = 1'b0;
                end
            end
            S_START_CHK: begin
                if (!cfg_ok) begin
                    err_cfg = 1'b1;
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop && head_fin) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            if (issue_last) begin
                i_d = '0;
                if (issue_fin) begin
                    issued_all_d = 1'b1;
                end else begin
                    p_d = p_q + CNT_WIDTH'(1);
                end
            end else begin
                i_d = i_q + ADDR_WIDTH'(1);
            end
        end
    end

    // Control state, counters, read pipeline flags and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            pass_q       <= '0;
            i_q          <= '0;
            p_q          <= '0;
            issued_all_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_fin_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pass_q       <= pass_d;
            i_q          <= i_d;
            p_q          <= p_d;
            issued_all_q <= issued_all_d;
            pend_q       <= issue;
            pend_last_q  <= issue_last;
            pend_fin_q   <= issue_fin;
            if (pend_q) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

    // Storage that survives reset: grid RAM, its read register and FIFO slots.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[cfg_wr_addr] <= cfg_wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[i_q];
        end
        if (pend_q) begin
            fifo_data[wr_ptr_q] <= rd_data_q;
            fifo_last[wr_ptr_q] <= pend_last_q;
            fifo_fin[wr_ptr_q]  <= pend_fin_q;
        end
    end

    // Stream outputs; everything reads zero whenever no beat is presented.
    always_comb begin
        busy               = (state_q != S_IDLE);
        m_axis_grid_tvalid = tvalid_int;
        m_axis_grid_tdata  = tvalid_int ? fifo_data[rd_ptr_q] : '0;
        m_axis_grid_tlast  = tvalid_int && fifo_last[rd_ptr_q];
        m_axis_grid_tid    = (ID_ENABLE != 0 && tvalid_int) ? IDW'(OUTPUT_ID) : '0;
        m_axis_grid_tdest  = (DEST_ENABLE != 0 && tvalid_int) ? DSW'(OUTPUT_DEST) : '0;
        m_axis_grid_tuser  = '0;
        if (USER_ENABLE != 0) begin
            m_axis_grid_tuser[0] = tvalid_int && head_fin;
        end
    end

endmodule

// File: tb/tb_kan_grid_streamer.sv
// tb/tb_kan_grid_streamer.sv - scoreboard bench for kan_grid_streamer
module tb_kan_grid_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_en;
    logic [5:0]  cfg_wr_addr;
    logic [15:0] cfg_wr_data;
    logic        start;
    logic [6:0]  grid_len;
    logic [15:0] pass_count;
    logic        busy, done, err_cfg;
    logic [15:0] tdata;
    logic        tvalid, tready, tlast;
    logic [7:0]  tid;
    logic [0:0]  tdest;
    logic [7:0]  tuser;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        u;
    } beat_t;

    beat_t       exp_q[$];
    logic [15:0] ram_m [64];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_v = -1;
    int          done_cyc = -1;
    int          beats = 0;
    bit          rand_ready = 1'b0;
    bit          hold = 1'b0;
    logic [24:0] hold_v;

    kan_grid_streamer #(
        .ID_ENABLE   (1),
        .USER_ENABLE (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_wr_en          (cfg_wr_en),
        .cfg_wr_addr        (cfg_wr_addr),
        .cfg_wr_data        (cfg_wr_data),
        .start              (start),
        .grid_len           (grid_len),
        .pass_count         (pass_count),
        .busy               (busy),
        .done               (done),
        .err_cfg            (err_cfg),
        .m_axis_grid_tdata  (tdata),
        .m_axis_grid_tvalid (tvalid),
        .m_axis_grid_tready (tready),
        .m_axis_grid_tlast  (tlast),
        .m_axis_grid_tid    (tid),
        .m_axis_grid_tdest  (tdest),
        .m_axis_grid_tuser  (tuser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks hold stability.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check(tvalid && ({tdata, tlast, tuser} == hold_v), "stable_while_stalled",
                      {tvalid, tdata, tlast, tuser}, {1'b1, hold_v});
            end
            if (tvalid && first_v < 0) first_v = cyc;
            if (tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", tdata, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tdata, tlast, tuser} == {e.d, e.l, 7'd0, e.u}, "beat_data_last_user",
                          {tdata, tlast, tuser}, {e.d, e.l, 7'd0, e.u});
                    check(tid == 8'd1 && tdest == 1'b0, "beat_tid_tdest", {tid, tdest}, 9'h002);
                end
            end
            hold   = tvalid && !tready;
            hold_v = {tdata, tlast, tuser};
        end
    end

    task automatic wr(input int addr, input logic [15:0] data);
        @(posedge clk); #1;
        cfg_wr_en = 1'b1; cfg_wr_addr = 6'(addr); cfg_wr_data = data;
        ram_m[addr] = data;
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
    endtask

    task automatic push_exp(input int len, input int np);
        beat_t e;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < len; i++) begin
                e.d = ram_m[i];
                e.l = (i == len - 1);
                e.u = e.l && (p == np - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run(input int len, input int np, input bit exp_err, input bit timing);
        int s;
        bit got;
        if (!exp_err) push_exp(len, np);
        first_v = -1;
        @(posedge clk); #1;
        start = 1'b1; grid_len = 7'(len); pass_count = 16'(np); s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
                check(err_cfg == exp_err, "err_cfg_with_done", err_cfg, exp_err);
                check(busy, "busy_on_done", busy, 1);
            end
        end
        check(got, "done_seen", got, 1);
        if (exp_err) begin
            check(first_v == -1, "no_beats_on_err", first_v, -1);
        end else begin
            check(exp_q.size() == 0, "all_beats_seen", exp_q.size(), 0);
        end
        if (timing && !exp_err) begin
            check(first_v - s <= 3, "first_tvalid_latency", first_v - s, 3);
            check(done_cyc - first_v == len * np, "no_idle_and_done_next", done_cyc - first_v, len * np);
        end
        @(posedge clk); #1;
        check(!busy && !done, "idle_after_done", {busy, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        start = 1'b0; grid_len = '0; pass_count = '0; tready = 1'b1;
        for (int k = 0; k < 64; k++) ram_m[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check(!tvalid && !busy && !done && !err_cfg, "reset_outputs",
              {tvalid, busy, done, err_cfg}, 0);
        rst = 1'b0;

        // T1: basic replay, tready held high
        wr(0, 16'h1000); wr(1, 16'h2000); wr(2, 16'h3000); wr(3, 16'h4000);
        run(4, 3, 1'b0, 1'b1);

        // T2: same with random backpressure
        rand_ready = 1'b1;
        run(4, 3, 1'b0, 1'b0);
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);

        // T3: illegal configurations
        run(0, 3, 1'b1, 1'b0);
        run(65, 3, 1'b1, 1'b0);
        run(4, 0, 1'b1, 1'b0);

        // T4: restart and RAM write while busy are both dropped
        fork
            run(4, 3, 1'b0, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1;
                start = 1'b1; grid_len = 7'd2;
                cfg_wr_en = 1'b1; cfg_wr_addr = 6'd2; cfg_wr_data = 16'hDEAD;
                @(posedge clk); #1;
                start = 1'b0; cfg_wr_en = 1'b0; grid_len = 7'd4;
            end
        join
        repeat (3) @(posedge clk);

        // T5: reset after the fifth beat, then rerun from RAM[0]
        push_exp(4, 3);
        beats = 0;
        @(posedge clk); #1;
        start = 1'b1; grid_len = 7'd4; pass_count = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && beats < 5; k++) begin
            @(negedge clk); #1;
        end
        check(beats == 5, "five_beats_before_reset", beats, 5);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check(!tvalid && !busy, "async_reset_mid_run", {tvalid, busy}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        run(4, 3, 1'b0, 1'b1);

        // single-point grid: tlast on every beat
        run(1, 2, 1'b0, 1'b1);

        // T6: full-depth grid
        for (int k = 0; k < 64; k++) wr(k, 16'(k));
        run(64, 2, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        check(exp_q.size() == 0 && !tvalid, "scoreboard_empty_at_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
